display_mux_sched: RTL and testbench
====================================

// Module: display_mux_sched
// PURPOSE
//  Time-division scheduler for the shared seven-segment decoder that drives the dual-digit display.
//  Alternates the decoder input between digit0 and digit1 and enables the matching anode.
//  Inserts a programmable blanking gap between digits so no ghosting occurs.
//  Guarantees at most one anode is on in any cycle. Sits between the switch inputs and the
//  hex-to-seven-segment decoder in the lab2 top level.
// PARAMETERS
//  DWELL_CYCLES  24000  clocks each digit is lit (>=1); ~1 kHz/digit at 48 MHz HSOSC
//  BLANK_CYCLES  480    clocks both anodes off between digits (0 = no gap states)
//  CNT_W         $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)  derived; width of dwell counter
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  en          in   1  display enable; low forces display dark
//  digit0      in   4  hex value for digit 0 (switch bank 1)
//  digit1      in   4  hex value for digit 1 (switch bank 2)
//  hex_sel     out  4  value routed to the shared seven-segment decoder (registered)
//  anode_n     out  2  active-low anode enables, [0]=digit0, [1]=digit1 (registered)
//  frame_tick  out  1  one-cycle pulse at completion of each full two-digit frame
// BEHAVIOUR
//  - One clock domain. Reset is sampled on posedge clk only.
//  - Reset values: state=IDLE, cnt=0, hex_sel=4'h0, anode_n=2'b11, frame_tick=0.
//  - FSM states: IDLE, SHOW0, GAP0, SHOW1, GAP1.
//  - IDLE: anode_n=11. If en=1, go to SHOW0 the next cycle, with cnt=0 and hex_sel<=digit0.
//  - SHOW0: anode_n=10. cnt increments each clock.
//    - At cnt==DWELL_CYCLES-1, go to GAP0 with cnt=0.
//    - If BLANK_CYCLES==0, go instead to SHOW1 with hex_sel<=digit1.
//  - GAP0: anode_n=11, hex_sel holds.
//    - At cnt==BLANK_CYCLES-1, go to SHOW1 with cnt=0 and hex_sel<=digit1.
//  - SHOW1 / GAP1: mirror SHOW0 / GAP0, returning to SHOW0 with hex_sel<=digit0.
//  - frame_tick=1 for exactly the cycle in which the FSM leaves SHOW1 or GAP1 to go to SHOW0.
//    This is the last cycle of GAP1, or the last cycle of SHOW1 when BLANK_CYCLES==0.
//  - hex_sel is latched only on entry to a SHOW state. Changes on digit0/digit1 during
//    SHOW/GAP take effect at the next entry of that digit's SHOW state.
//  - Outputs are registered and take their state values in the same cycle the state register
//    takes a state. Latency from en rise to first anode on = 1 clock.
//  - en=0 in any state: next cycle is IDLE, anode_n=11, cnt=0, frame_tick=0. hex_sel holds.
//    On re-enable the sequence restarts at SHOW0.
//  - reset mid-frame: next cycle takes the reset values regardless of en or state.
//  - Invariant: anode_n!=2'b00 in every cycle, including reset and en transitions.
//  - Steady-state period = 2*(DWELL_CYCLES+BLANK_CYCLES) clocks. Each anode duty =
//    DWELL_CYCLES per period.
//  - cnt is unsigned CNT_W bits and is cleared on every state change. It never wraps past the
//    terminal count.
// TESTING  (bench parameters: DWELL_CYCLES=4, BLANK_CYCLES=2)
//  1. reset=1 for 2 clk, en=1 -> anode_n=11, hex_sel=0, frame_tick=0 while reset is high.
//     SHOW0 is on the first clk after reset drops.
//  2. digit0=5, digit1=8, en=1 -> repeating pattern:
//     - 4 clk anode_n=10 with hex_sel=5
//     - 2 clk anode_n=11
//     - 4 clk anode_n=01 with hex_sel=8
//     - 2 clk anode_n=11
//     The period is 12 clk, and frame_tick pulses once per 12 clk on the last GAP1 cycle.
//  3. digit0 changes 5->A during the 2nd SHOW0 cycle -> hex_sel stays 5 until the next SHOW0
//     entry, then shows A.
//  4. en dropped during SHOW1 -> next clk anode_n=11 and stays 11. en raised -> SHOW0 is on
//     1 clk later.
//  5. reset pulsed for 1 clk during GAP0 -> outputs at reset values on the next clk, then the
//     sequence restarts at SHOW0.
//  6. Concurrent assertion on every posedge over all of the above: anode_n!=2'b00.
//     A rerun with BLANK_CYCLES=0 gives an 8 clk period with no 11 cycles while en=1.

Source files
------------

// File: rtl/display_mux_sched.sv
// Two-digit time-division scheduler for a shared seven-segment decoder.
// Alternates digits with an optional blanking gap; at most one anode is ever lit.
module display_mux_sched #(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [3:0] hex_sel,
  output logic [1:0] anode_n,
  output logic       frame_tick
);

  localparam int MAXC =
    (DWELL_CYCLES > BLANK_CYCLES) ?
    DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  localparam logic [CNT_W-1:0] DW_LAST =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BL_LAST =
    HAS_GAP ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SHOW0,
    GAP0,
    SHOW1,
    GAP1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hex_q, hex_d;
  logic [1:0]       anode_q, anode_d;
  logic             tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW0;
          cnt_d   = '0;
          hex_d   = digit0;
        end
        SHOW0: begin
          if (cnt_q == DW_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = GAP0;
            end else begin
              state_d = SHOW1;
              hex_d   = digit1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        GAP0: begin
          if (cnt_q == BL_LAST) begin
            state_d = SHOW1;
            cnt_d   = '0;
            hex_d   = digit1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        SHOW1: begin
          if (cnt_q == DW_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = GAP1;
            end else begin
              state_d = SHOW0;
              hex_d   = digit0;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        GAP1: begin
          if (cnt_q == BL_LAST) begin
            state_d = SHOW0;
            cnt_d   = '0;
            hex_d   = digit0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    anode_d = 2'b11;
    if (state_d == SHOW0) anode_d = 2'b10;
    if (state_d == SHOW1) anode_d = 2'b01;
  end

  // Tick is registered, so assert it on entry to the frame's final cycle.
  always_comb begin
    tick_d = 1'b0;
    if (HAS_GAP) begin
      tick_d = (state_d == GAP1) &&
               (cnt_d == BL_LAST);
    end else begin
      tick_d = (state_d == SHOW1) &&
               (cnt_d == DW_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hex_q   <= 4'h0;
      anode_q <= 2'b11;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign hex_sel    = hex_q;
  assign anode_n    = anode_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_mux_sched.sv
// Directed bench for display_mux_sched: one instance with a blanking gap,
// one without, driven by the same stimulus.
module tb_display_mux_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] digit0;
  logic [3:0] digit1;

  logic [3:0] hex_a;
  logic [1:0] an_a;
  logic       ft_a;
  logic [3:0] hex_b;
  logic [1:0] an_b;
  logic       ft_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  display_mux_sched #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .digit0    (digit0),
    .digit1    (digit1),
    .hex_sel   (hex_a),
    .anode_n   (an_a),
    .frame_tick(ft_a)
  );

  display_mux_sched #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(0)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .digit0    (digit0),
    .digit1    (digit1),
    .hex_sel   (hex_b),
    .anode_n   (an_b),
    .frame_tick(ft_b)
  );

  task automatic chk(
    input string    tag,
    input int       k,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d observed=%h expected=%h",
             tag, k, obs, exp);
    end
  endtask

  // k counts cycles since SHOW0 entry; returns {anode, hex, tick}.
  function automatic logic [6:0] exp_gap(
    input int k, input logic [3:0] d0,
    input logic [3:0] d1
  );
    int p;
    p = k % 12;
    if (p < 4)       return {2'b10, d0, 1'b0};
    else if (p < 6)  return {2'b11, d0, 1'b0};
    else if (p < 10) return {2'b01, d1, 1'b0};
    else             return {2'b11, d1, p == 11};
  endfunction

  function automatic logic [6:0] exp_nogap(
    input int k, input logic [3:0] d0,
    input logic [3:0] d1
  );
    int p;
    p = k % 8;
    if (p < 4) return {2'b10, d0, 1'b0};
    else       return {2'b01, d1, p == 7};
  endfunction

  task automatic chk_both(
    input int k,
    input logic [6:0] ea,
    input logic [6:0] eb
  );
    chk("gap_anode", k, {6'd0, an_a},  {6'd0, ea[6:5]});
    chk("gap_hex",   k, {4'd0, hex_a}, {4'd0, ea[4:1]});
    chk("gap_tick",  k, {7'd0, ft_a},  {7'd0, ea[0]});
    chk("nog_anode", k, {6'd0, an_b},  {6'd0, eb[6:5]});
    chk("nog_hex",   k, {4'd0, hex_b}, {4'd0, eb[4:1]});
    chk("nog_tick",  k, {7'd0, ft_b},  {7'd0, eb[0]});
  endtask

  task automatic chk_reset_vals(input int k);
    chk_both(k, {2'b11, 4'h0, 1'b0},
                {2'b11, 4'h0, 1'b0});
  endtask

  always @(negedge clk) begin
    checks++;
    assert (an_a !== 2'b00 && an_b !== 2'b00) else begin
      fails++;
      $error("FAIL both_anodes observed=%b/%b required=not 00",
             an_a, an_b);
    end
  end

  initial begin
    logic [3:0] da;
    logic [3:0] db;
    reset  = 1'b1;
    en     = 1'b1;
    digit0 = 4'h5;
    digit1 = 4'h8;

    @(posedge clk); #1;
    chk_reset_vals(-2);
    @(posedge clk); #1;
    chk_reset_vals(-1);
    reset = 1'b0;

    for (int k = 0; k <= 42; k++) begin
      @(posedge clk); #1;
      da = (k >= 24) ? 4'hA : 4'h5;
      db = (k >= 16) ? 4'hA : 4'h5;
      chk_both(k, exp_gap(k, da, 4'h8),
                  exp_nogap(k, db, 4'h8));
      if (k == 13) digit0 = 4'hA;
    end

    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_both(100 + k, {2'b11, 4'h8, 1'b0},
                        {2'b11, 4'hA, 1'b0});
    end
    en = 1'b1;

    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      chk_both(200 + k, exp_gap(k, 4'hA, 4'h8),
                        exp_nogap(k, 4'hA, 4'h8));
    end

    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals(300);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk_both(400 + k, exp_gap(k, 4'hA, 4'h8),
                        exp_nogap(k, 4'hA, 4'h8));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
